// File: rtl/prism_config_reader.sv
`default_nettype none
// ============================================================================
//  Module   : prism_config_reader
//  Purpose  : On each CPU request, reads one 32-bit word from the PRISM latch
//             chain, returns it with a one-cycle valid strobe, and keeps an XOR
//             checksum over each full pass.
//  Revision : 1.0  initial release
// ============================================================================
module prism_config_reader #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    // Derived from WIDTH and DEPTH; not meant to be overridden.
    localparam int NWORDS = DEPTH * WIDTH / 32,
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*DEPTH-1:0] config_bus,
    input  logic                   loader_busy,
    input  logic                   start,
    input  logic                   rd_req,
    output logic [31:0]            rd_data,
    output logic                   rd_valid,
    output logic                   rd_last,
    output logic [IDX_W-1:0]       word_idx,
    output logic                   busy,
    output logic [31:0]            checksum,
    output logic                   checksum_valid,
    output logic                   rd_overrun
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;
    logic             r_rd_last;
    logic [IDX_W-1:0] r_word_idx;
    logic [31:0]      r_checksum;
    logic             r_checksum_valid;
    logic             r_rd_overrun;
    logic             w_overrun_set;
    logic [31:0]      w_words [NWORDS];

    for (genvar k = 0; k < NWORDS; k++) begin : g_words
        assign w_words[k] = config_bus[32*k +: 32];
    end

    // A request in PRESENT is accepted directly, as if the engine were idle.
    always_comb begin
        w_next        = r_state;
        w_overrun_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req) w_next = loader_busy ? WAIT_LD : CAPTURE;
            end
            WAIT_LD: begin
                w_overrun_set = rd_req;
                if (!loader_busy) w_next = CAPTURE;
            end
            CAPTURE: begin
                w_overrun_set = rd_req;
                w_next        = PRESENT;
            end
            PRESENT: begin
                if (rd_req) w_next = loader_busy ? WAIT_LD : CAPTURE;
                else        w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (start) begin
            w_next        = IDLE;
            w_overrun_set = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_rd_data        <= 32'd0;
            r_rd_valid       <= 1'b0;
            r_rd_last        <= 1'b0;
            r_word_idx       <= '0;
            r_checksum       <= 32'd0;
            r_checksum_valid <= 1'b0;
            r_rd_overrun     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (start) begin
                r_word_idx       <= '0;
                r_checksum       <= 32'd0;
                r_checksum_valid <= 1'b0;
                r_rd_overrun     <= 1'b0;
            end else begin
                if (w_overrun_set) r_rd_overrun <= 1'b1;
                // The output data register doubles as the capture register, so the
                // word is presented in the cycle right after CAPTURE.
                if (r_state == CAPTURE) begin
                    r_rd_data  <= w_words[r_word_idx];
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= (r_word_idx == C_LAST_IDX);
                end
                if (r_state == PRESENT) begin
                    if (r_word_idx == '0) begin
                        r_checksum       <= r_rd_data;
                        r_checksum_valid <= 1'b0;
                    end else begin
                        r_checksum <= r_checksum ^ r_rd_data;
                    end
                    if (r_word_idx == C_LAST_IDX) begin
                        r_word_idx       <= '0;
                        r_checksum_valid <= 1'b1;
                    end else begin
                        r_word_idx <= r_word_idx + 1'b1;
                    end
                end
            end
        end
    end

    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign rd_last        = r_rd_last;
    assign word_idx       = r_word_idx;
    assign busy           = (r_state != IDLE);
    assign checksum       = r_checksum;
    assign checksum_valid = r_checksum_valid;
    assign rd_overrun     = r_rd_overrun;

endmodule
`default_nettype wire

// File: tb/tb_prism_config_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prism_config_reader
//  Purpose  : Directed self-checking bench for prism_config_reader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prism_config_reader;

    localparam int WIDTH  = 64;
    localparam int DEPTH  = 8;
    localparam int NWORDS = DEPTH * WIDTH / 32;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH*DEPTH-1:0] config_bus;
    logic                   loader_busy;
    logic                   start;
    logic                   rd_req;
    logic [31:0]            rd_data;
    logic                   rd_valid;
    logic                   rd_last;
    logic [3:0]             word_idx;
    logic                   busy;
    logic [31:0]            checksum;
    logic                   checksum_valid;
    logic                   rd_overrun;

    int n_total = 0;
    int n_pass  = 0;

    prism_config_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .config_bus     (config_bus),
        .loader_busy    (loader_busy),
        .start          (start),
        .rd_req         (rd_req),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_last        (rd_last),
        .word_idx       (word_idx),
        .busy           (busy),
        .checksum       (checksum),
        .checksum_valid (checksum_valid),
        .rd_overrun     (rd_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pattern(input int mode);
        for (int k = 0; k < NWORDS; k++) begin
            if (mode == 0) config_bus[32*k +: 32] = 32'hA500_0000 | k;
            else           config_bus[32*k +: 32] = 32'h0000_0001 << k;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // rd_req is issued in cycle N; data is expected in N+2; the task returns in N+3.
    task automatic do_read(input logic [31:0] exp_data, input logic exp_last);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_eq("valid_n1", rd_valid, 0);
        tick();
        check_eq("valid_n2", rd_valid, 1);
        check_eq("rd_data", rd_data, exp_data);
        check_eq("rd_last", rd_last, exp_last);
        tick();
        check_eq("valid_pulse", rd_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rd_req = 1'b0; loader_busy = 1'b0;
        config_bus = '0;
        tick(); tick();
        rst_n = 1'b1;
        check_eq("rst_idx", word_idx, 0);
        check_eq("rst_data", rd_data, 0);
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_last", rd_last, 0);
        check_eq("rst_cks", checksum, 0);
        check_eq("rst_cksv", checksum_valid, 0);
        check_eq("rst_ovr", rd_overrun, 0);
        check_eq("rst_busy", busy, 0);

        // Full pass over the A5 pattern; its XOR over all 16 words is zero.
        set_pattern(0);
        for (int k = 0; k < NWORDS; k++) begin
            do_read(32'hA500_0000 | k, k == NWORDS - 1);
            if (k == 0) check_eq("cks_first", checksum, 32'hA500_0000);
        end
        check_eq("p1_idx_wrap", word_idx, 0);
        check_eq("p1_cks", checksum, 32'h0000_0000);
        check_eq("p1_cksv", checksum_valid, 1);
        check_eq("p1_ovr", rd_overrun, 0);

        // One-hot pattern.
        pulse_start();
        set_pattern(1);
        for (int k = 0; k < NWORDS; k++) do_read(32'h0000_0001 << k, k == NWORDS - 1);
        check_eq("p2_cks", checksum, 32'h0000_FFFF);
        check_eq("p2_cksv", checksum_valid, 1);
        do_read(32'h0000_0001, 1'b0);
        check_eq("p2_17_cks", checksum, 32'h0000_0001);
        check_eq("p2_17_cksv", checksum_valid, 0);
        check_eq("p2_17_idx", word_idx, 1);

        // Loader busy for 5 cycles; data must be sampled after busy drops.
        pulse_start();
        set_pattern(0);
        rd_req = 1'b1;
        loader_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            rd_req = 1'b0;
            check_eq("wait_valid", rd_valid, 0);
            check_eq("wait_busy", busy, 1);
            if (i == 5) begin
                loader_busy = 1'b0;
                config_bus[31:0] = 32'hDEAD_BEEF;
            end
        end
        tick();
        check_eq("wait_n6_valid", rd_valid, 0);
        tick();
        check_eq("wait_n7_valid", rd_valid, 1);
        check_eq("wait_data", rd_data, 32'hDEAD_BEEF);
        tick();
        check_eq("wait_idx", word_idx, 1);
        check_eq("wait_ovr", rd_overrun, 0);

        // A second request during CAPTURE is dropped and flags an overrun.
        rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        check_eq("ovr_valid", rd_valid, 1);
        check_eq("ovr_data", rd_data, 32'hA500_0001);
        check_eq("ovr_flag", rd_overrun, 1);
        tick();
        check_eq("ovr_valid_off", rd_valid, 0);
        check_eq("ovr_idx", word_idx, 2);
        tick(); tick(); tick();
        check_eq("ovr_no_second", rd_valid, 0);
        check_eq("ovr_sticky", rd_overrun, 1);
        check_eq("ovr_idx_hold", word_idx, 2);
        pulse_start();
        check_eq("ovr_cleared", rd_overrun, 0);

        // start together with rd_req after five reads.
        set_pattern(0);
        for (int k = 0; k < 5; k++) do_read(32'hA500_0000 | k, 1'b0);
        check_eq("pre_start_cks", checksum, 32'hA500_0004);
        start = 1'b1;
        rd_req = 1'b1;
        tick();
        start = 1'b0;
        rd_req = 1'b0;
        check_eq("st_idx", word_idx, 0);
        check_eq("st_cks", checksum, 0);
        check_eq("st_ovr", rd_overrun, 0);
        check_eq("st_busy", busy, 0);
        check_eq("st_data_kept", rd_data, 32'hA500_0004);
        tick();
        check_eq("st_no_valid", rd_valid, 0);
        tick();
        check_eq("st_no_valid2", rd_valid, 0);
        do_read(32'hA500_0000, 1'b0);

        // Reset asserted while in CAPTURE.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_eq("rc_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rc_valid", rd_valid, 0);
        check_eq("rc_data", rd_data, 0);
        check_eq("rc_idx", word_idx, 0);
        check_eq("rc_cks", checksum, 0);
        check_eq("rc_cksv", checksum_valid, 0);
        check_eq("rc_busy_off", busy, 0);
        tick();
        check_eq("rc_no_valid", rd_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
